fetch_prefetch_unit: RTL

//  Sequential instruction fetch stage with a parametrised prefetch buffer. It runs ahead of decode.
//  - Issues one-outstanding 32-bit READ requests on the memory interface.
//  - Tolerates any memory latency.
//  - Queues fetched words with their PCs in a FIFO for decode (valid/ready).
//  - Handles control-flow redirects mid-transaction by flushing the queue and discarding stale data.

---
 rtl/fetch_prefetch_unit_pkg.sv | 17 +
 rtl/fetch_prefetch_unit_fetch_buffer.sv | 67 ++++++
 rtl/fetch_prefetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the fetch/prefetch unit: FSM encodings and
// memory-interface request constants.
package fetch_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    localparam logic       MEM_DISABLE = 1'b0;
    localparam logic       MEM_ENABLE  = 1'b1;
    localparam logic       MEM_READ    = 1'b0;
    localparam logic [3:0] MASK_ALL    = 4'b1111;
    localparam logic [3:0] MASK_NONE   = 4'b0000;

endpackage

// File: rtl/fetch_prefetch_unit_fetch_buffer.sv
// Prefetch FIFO holding {pc, instruction} pairs.
// Flush has priority over push/pop, and a pop on empty is ignored.
module fetch_buffer #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential fetch stage: one outstanding read at a time, results queued with
// their PCs for decode; redirects flush the queue and discard in-flight data.
//
// state      | meaning
// FETCH_IDLE | no request outstanding; decide whether to issue
// FETCH_WAIT | request outstanding; response will be queued
// FETCH_DROP | request outstanding; response is stale and discarded
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instruction_valid_o,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] instruction_pc_o,
    input  logic            instruction_ready_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            memory_interface_enable_o,
    output logic            memory_interface_state_o,
    output logic [XLEN-1:0] memory_interface_address_o,
    output logic [3:0]      memory_interface_frame_mask_o,
    input  logic            memory_interface_ready_i,
    input  logic [XLEN-1:0] memory_interface_data_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] pc_plus4;
    logic [CW:0]     count_after;
    logic [CW-1:0]   count;
    logic            push, pop, flush, full, empty, busy;

    // Word-granular increment; wraps past the top of the address space.
    assign pc_plus4 = {fetch_pc_q[XLEN-1:2] + (XLEN-2)'(1), 2'b00};

    assign pop         = instruction_valid_o && instruction_ready_i;
    assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid_i) begin
            flush      = 1'b1;
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            if (state_q != FETCH_IDLE) begin
                state_d = memory_interface_ready_i ? FETCH_IDLE : FETCH_DROP;
            end
        end else begin
            unique case (state_q)
                FETCH_IDLE: begin
                    if (enable_i && !full) begin
                        state_d    = FETCH_WAIT;
                        req_addr_d = fetch_pc_q;
                    end
                end
                FETCH_WAIT: begin
                    if (memory_interface_ready_i) begin
                        push       = 1'b1;
                        fetch_pc_d = pc_plus4;
                        if (enable_i && (count_after < (CW+1)'(DEPTH))) begin
                            req_addr_d = pc_plus4;
                        end else begin
                            state_d = FETCH_IDLE;
                        end
                    end
                end
                FETCH_DROP: begin
                    if (memory_interface_ready_i) state_d = FETCH_IDLE;
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign busy                          = (state_q != FETCH_IDLE);
    assign memory_interface_enable_o     = busy ? MEM_ENABLE : MEM_DISABLE;
    assign memory_interface_state_o      = MEM_READ;
    assign memory_interface_address_o    = busy ? req_addr_q : '0;
    assign memory_interface_frame_mask_o = busy ? MASK_ALL : MASK_NONE;
    assign fetch_pc_o                    = fetch_pc_q;

    fetch_buffer #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({req_addr_q, memory_interface_data_i}),
        .data_o  ({instruction_pc_o, instruction_o}),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign instruction_valid_o = !empty;

endmodule
